// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register and one-entry hold buffer
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_instr,
   output logic [5:0]  if_id_opcode,
   output logic [4:0]  if_id_rs,
   output logic [4:0]  if_id_rt,
   output logic [4:0]  if_id_rd,
   output logic [5:0]  if_id_funct,
   output logic [15:0] if_id_imm16
);

   typedef enum logic {FETCH, HELD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] hold_buf, hold_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic [31:0] pc4_q, pc4_nxt;
   logic        valid_q, valid_nxt;
   logic        xfer;
   logic [31:0] pc_plus4;
   logic [31:0] redirect;

   assign imem_req  = (state == FETCH) && !reset;
   assign imem_addr = pc;
   assign xfer      = imem_req && imem_ready;
   assign pc_plus4  = pc + 32'd4;
   assign redirect  = branch_target & ~32'd3;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      hold_nxt  = hold_buf;
      instr_nxt = instr_q;
      pc4_nxt   = pc4_q;
      valid_nxt = valid_q;
      case (state)
         FETCH: begin
            if (flush) begin
               pc_nxt    = redirect;
               valid_nxt = 1'b0;
            end else if (xfer && !stall) begin
               instr_nxt = imem_rdata;
               pc4_nxt   = pc_plus4;
               valid_nxt = 1'b1;
               pc_nxt    = pc_plus4;
            end else if (xfer) begin
               // Memory already returned the word; park it until ID can take it.
               hold_nxt  = imem_rdata;
               state_nxt = HELD;
            end else if (!stall) begin
               valid_nxt = 1'b0;
            end
         end
         HELD: begin
            if (flush) begin
               pc_nxt    = redirect;
               valid_nxt = 1'b0;
               state_nxt = FETCH;
            end else if (!stall) begin
               instr_nxt = hold_buf;
               pc4_nxt   = pc_plus4;
               valid_nxt = 1'b1;
               pc_nxt    = pc_plus4;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         hold_buf <= 32'd0;
         instr_q  <= 32'd0;
         pc4_q    <= 32'd0;
         valid_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         hold_buf <= hold_nxt;
         instr_q  <= instr_nxt;
         pc4_q    <= pc4_nxt;
         valid_q  <= valid_nxt;
      end
   end

   assign if_id_valid  = valid_q;
   assign if_id_pc4    = pc4_q;
   assign if_id_instr  = instr_q;
   assign if_id_opcode = instr_q[31:26];
   assign if_id_rs     = instr_q[25:21];
   assign if_id_rt     = instr_q[20:16];
   assign if_id_rd     = instr_q[15:11];
   assign if_id_funct  = instr_q[5:0];
   assign if_id_imm16  = instr_q[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed checks of fetch_stage against a queue-based reference
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        imem_ready = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_pc4, if_id_instr;
   logic [5:0]  if_id_opcode, if_id_funct;
   logic [4:0]  if_id_rs, if_id_rt, if_id_rd;
   logic [15:0] if_id_imm16;

   logic        req2;
   logic [31:0] addr2, rdata2;
   logic        valid2;
   logic [31:0] pc4_2, instr2;
   logic [5:0]  opcode2, funct2;
   logic [4:0]  rs2, rt2, rd2;
   logic [15:0] imm2;

   logic        mem_mode = 1'b0;
   logic        inject_en = 1'b0;
   logic [31:0] inject_word = 32'd0;

   int n_tests = 0;
   int n_fail = 0;

   // Reference state: the hold buffer is a queue that is either empty or holds one word.
   logic [31:0] m_pc = 32'd0;
   logic        m_valid = 1'b0;
   logic [31:0] m_instr = 32'd0;
   logic [31:0] m_pc4 = 32'd0;
   logic [31:0] hq[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic mode, input logic [31:0] a);
      return mode ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) : a;
   endfunction

   assign imem_rdata = inject_en ? inject_word : memf(mem_mode, imem_addr);
   assign rdata2     = (addr2 == 32'hFFFF_FFFC) ? 32'h2022_FFFF : addr2;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_id_valid(if_id_valid), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
      .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
      .if_id_funct(if_id_funct), .if_id_imm16(if_id_imm16)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0), .branch_target(32'd0),
      .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1), .imem_rdata(rdata2),
      .if_id_valid(valid2), .if_id_pc4(pc4_2), .if_id_instr(instr2),
      .if_id_opcode(opcode2), .if_id_rs(rs2), .if_id_rt(rt2), .if_id_rd(rd2),
      .if_id_funct(funct2), .if_id_imm16(imm2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_step();
      logic [31:0] word;
      if (reset) begin
         m_pc = 32'd0;
         hq.delete();
         m_valid = 1'b0;
         m_instr = 32'd0;
         m_pc4 = 32'd0;
      end else if (hq.size() == 0) begin
         word = inject_en ? inject_word : memf(mem_mode, m_pc);
         if (flush) begin
            m_pc = branch_target & ~32'd3;
            m_valid = 1'b0;
         end else if (imem_ready && !stall) begin
            m_instr = word;
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
         end else if (imem_ready) begin
            hq.push_back(word);
         end else if (!stall) begin
            m_valid = 1'b0;
         end
      end else begin
         if (flush) begin
            hq.delete();
            m_pc = branch_target & ~32'd3;
            m_valid = 1'b0;
         end else if (!stall) begin
            m_instr = hq.pop_front();
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic compare_all();
      chk("m_req",    32'(imem_req), 32'(!reset && hq.size() == 0));
      chk("m_addr",   imem_addr, m_pc);
      chk("m_valid",  32'(if_id_valid), 32'(m_valid));
      chk("m_instr",  if_id_instr, m_instr);
      chk("m_pc4",    if_id_pc4, m_pc4);
      chk("m_fields", {if_id_opcode, if_id_rs, if_id_rt, if_id_rd, if_id_funct[5:0], 5'd0},
                      {m_instr[31:11], m_instr[5:0], 5'd0});
      chk("m_imm16",  32'(if_id_imm16), 32'(m_instr[15:0]));
   endtask

   initial begin
      fork
         forever begin
            @(posedge clk or posedge reset);
            model_step();
         end
         forever begin
            @(posedge clk);
            #1;
            compare_all();
         end
      join_none

      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_id_valid), 32'd0);
      chk("rst_instr", if_id_instr, 32'd0);
      chk("rst_pc4",   if_id_pc4, 32'd0);
      chk("rst_addr",  imem_addr, 32'd0);
      chk("rst_op",    32'(if_id_opcode), 32'd0);

      // Cycle 1 after release
      reset = 1'b0;
      #1;
      chk("c1_req",   32'(imem_req), 32'd1);
      chk("c1_addr",  imem_addr, 32'd0);
      chk("c1_valid", 32'(if_id_valid), 32'd0);
      chk("w_addr1",  addr2, 32'hFFFF_FFFC);

      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("seq_addr",  imem_addr, 32'(4 * (k + 1)));
         chk("seq_valid", 32'(if_id_valid), 32'd1);
         chk("seq_instr", if_id_instr, 32'(4 * k));
         chk("seq_pc4",   if_id_pc4, 32'(4 * k + 4));
         if (k == 0) begin
            chk("w_addr2",  addr2, 32'd0);
            chk("w_pc4",    pc4_2, 32'd0);
            chk("w_opcode", 32'(opcode2), 32'h08);
            chk("w_rs",     32'(rs2), 32'd1);
            chk("w_rt",     32'(rt2), 32'd2);
            chk("w_rd",     32'(rd2), 32'd31);
            chk("w_funct",  32'(funct2), 32'h3F);
            chk("w_imm16",  32'(imm2), 32'hFFFF);
         end
      end

      // pc = 0x10: memory not ready for three cycles
      imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("nr_addr",  imem_addr, 32'h10);
         chk("nr_valid", 32'(if_id_valid), 32'd0);
      end
      imem_ready = 1'b1;
      @(negedge clk);
      chk("nr_instr", if_id_instr, 32'h10);
      chk("nr_pc4",   if_id_pc4, 32'h14);
      chk("nr_valid1", 32'(if_id_valid), 32'd1);

      // Stall coincident with transfer of 0xDEADBEEF at pc 0x14
      inject_en = 1'b1;
      inject_word = 32'hDEAD_BEEF;
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         inject_en = 1'b0;
         chk("st_req",   32'(imem_req), 32'd0);
         chk("st_instr", if_id_instr, 32'h10);
         chk("st_pc4",   if_id_pc4, 32'h14);
      end
      stall = 1'b0;
      @(negedge clk);
      chk("st_rel_instr", if_id_instr, 32'hDEAD_BEEF);
      chk("st_rel_pc4",   if_id_pc4, 32'h18);
      chk("st_rel_addr",  imem_addr, 32'h18);
      chk("st_rel_req",   32'(imem_req), 32'd1);

      // Enter HELD, then flush to 0x103
      stall = 1'b1;
      @(negedge clk);
      chk("h_req", 32'(imem_req), 32'd0);
      flush = 1'b1;
      branch_target = 32'h103;
      @(negedge clk);
      chk("hf_valid", 32'(if_id_valid), 32'd0);
      chk("hf_addr",  imem_addr, 32'h100);
      chk("hf_req",   32'(imem_req), 32'd1);

      // Flush + stall + transfer in one cycle
      branch_target = 32'h200;
      @(negedge clk);
      chk("fs_addr",  imem_addr, 32'h200);
      chk("fs_valid", 32'(if_id_valid), 32'd0);
      chk("fs_req",   32'(imem_req), 32'd1);
      flush = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      chk("fs_instr", if_id_instr, 32'h200);
      chk("fs_pc4",   if_id_pc4, 32'h204);

      // Randomized phase
      mem_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 199) == 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         imem_ready = ($urandom_range(0, 9) < 7);
         branch_target = $urandom;
      end
      @(negedge clk);
      reset = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
